// File: rtl/czonotope_streamer_if.sv
// CZonotope container: dimensions plus center c, generators G,
// constraint matrix A and constraint vector b.
interface CZonotope #(
    parameter int DATA_WIDTH = 32,
    parameter int NMAX       = 10,
    parameter int NGMAX      = 5,
    parameter int NCMAX      = 3
);
    logic [7:0]            n;
    logic [7:0]            ng;
    logic [7:0]            nc;
    logic [DATA_WIDTH-1:0] c [NMAX];
    logic [DATA_WIDTH-1:0] G [NMAX][NGMAX];
    logic [DATA_WIDTH-1:0] A [NCMAX][NGMAX];
    logic [DATA_WIDTH-1:0] b [NCMAX];

    modport rd (input n, ng, nc, c, G, A, b);
    modport wr (output n, ng, nc, c, G, A, b);
endinterface

// File: rtl/czonotope_streamer.sv
// czonotope_streamer: drains a CZonotope onto a valid/ready word stream.
// Frame: header, c, G (row-major), A (row-major), b.
// Optional feature macro: CZ_STREAM_CHECKSUM_EN appends an XOR checksum word.
module czonotope_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int NMAX       = 10,
    parameter int NGMAX      = 5,
    parameter int NCMAX      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    CZonotope.rd                  Z,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o
);
    localparam int NIW = (NMAX  > 1) ? $clog2(NMAX)  : 1;
    localparam int GIW = (NGMAX > 1) ? $clog2(NGMAX) : 1;
    localparam int CIW = (NCMAX > 1) ? $clog2(NCMAX) : 1;
    localparam int RW  = (NIW > CIW) ? NIW : CIW;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_CEN  = 3'd2;
    localparam logic [2:0] ST_GEN  = 3'd3;
    localparam logic [2:0] ST_CON  = 3'd4;
    localparam logic [2:0] ST_BVEC = 3'd5;
    localparam logic [2:0] ST_CSUM = 3'd6;
    localparam logic [2:0] ST_DONE = 3'd7;

`ifdef CZ_STREAM_CHECKSUM_EN
    localparam logic [2:0] END_SEC = ST_CSUM;
`else
    localparam logic [2:0] END_SEC = ST_DONE;
`endif

    // State names the section of the word currently held in the output
    // register; row/col index that word inside its section.
    logic [2:0]            state_q;
    logic [RW-1:0]         row_q;
    logic [GIW-1:0]        col_q;
    logic [7:0]            n_q, ng_q, nc_q;
    logic                  ovs_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, last_q, busy_q, done_q, err_q;
    logic [DATA_WIDTH-1:0] csum_q;

    logic [2:0]            nxt_s;
    logic [RW-1:0]         nxt_r;
    logic [GIW-1:0]        nxt_c;
    logic                  nxt_last;
    logic [DATA_WIDTH-1:0] nxt_word;
    logic [DATA_WIDTH-1:0] hdr_w;
    logic                  ovs_in;
    logic                  start_last;

    // First non-empty section following section s (END_SEC when none left).
    function automatic logic [2:0] next_sec(input logic [2:0] s,
                                            input logic n_nz,
                                            input logic ng_nz,
                                            input logic nc_nz,
                                            input logic ovs);
        logic [2:0] r;
        r = END_SEC;
        if (s < ST_BVEC && nc_nz)          r = ST_BVEC;
        if (s < ST_CON  && nc_nz && ng_nz) r = ST_CON;
        if (s < ST_GEN  && n_nz  && ng_nz) r = ST_GEN;
        if (s < ST_CEN  && n_nz)           r = ST_CEN;
        if (ovs)                           r = END_SEC;
        if (s >= ST_CSUM)                  r = ST_DONE;
        return r;
    endfunction

    // True when (r,c) is the final element of section s.
    function automatic logic at_end(input logic [2:0] s,
                                    input logic [7:0] r,
                                    input logic [7:0] c,
                                    input logic [7:0] n,
                                    input logic [7:0] ng,
                                    input logic [7:0] nc);
        logic e;
        case (s)
            ST_CEN:  e = (r == n - 8'd1);
            ST_GEN:  e = (r == n - 8'd1) && (c == ng - 8'd1);
            ST_CON:  e = (r == nc - 8'd1) && (c == ng - 8'd1);
            ST_BVEC: e = (r == nc - 8'd1);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Header word and last-flag for a frame about to start, from live Z dims.
    always_comb begin
        ovs_in = (int'(Z.n) > NMAX) || (int'(Z.ng) > NGMAX) || (int'(Z.nc) > NCMAX);
        hdr_w = '0;
        hdr_w[31:0] = {(ovs_in ? 8'hCE : 8'hC2), Z.nc, Z.ng, Z.n};
        start_last = (next_sec(ST_HDR, Z.n != 8'd0, Z.ng != 8'd0, Z.nc != 8'd0, ovs_in)
                      == ST_DONE);
    end

    // Successor position of the current word, its element fetch and last flag.
    always_comb begin
        nxt_s = state_q;
        nxt_r = row_q;
        nxt_c = col_q;
        if (at_end(state_q, 8'(row_q), 8'(col_q), n_q, ng_q, nc_q)) begin
            nxt_s = next_sec(state_q, n_q != 8'd0, ng_q != 8'd0, nc_q != 8'd0, ovs_q);
            nxt_r = '0;
            nxt_c = '0;
        end else begin
            case (state_q)
                ST_GEN, ST_CON: begin
                    if (8'(col_q) == ng_q - 8'd1) begin
                        nxt_c = '0;
                        nxt_r = row_q + 1'b1;
                    end else begin
                        nxt_c = col_q + 1'b1;
                    end
                end
                default: nxt_r = row_q + 1'b1;
            endcase
        end

        nxt_last = at_end(nxt_s, 8'(nxt_r), 8'(nxt_c), n_q, ng_q, nc_q) &&
                   (next_sec(nxt_s, n_q != 8'd0, ng_q != 8'd0, nc_q != 8'd0, ovs_q)
                    == ST_DONE);

        case (nxt_s)
            ST_CEN:  nxt_word = Z.c[nxt_r[NIW-1:0]];
            ST_GEN:  nxt_word = Z.G[nxt_r[NIW-1:0]][nxt_c];
            ST_CON:  nxt_word = Z.A[nxt_r[CIW-1:0]][nxt_c];
            ST_BVEC: nxt_word = Z.b[nxt_r[CIW-1:0]];
            ST_CSUM: nxt_word = csum_q;
            default: nxt_word = '0;
        endcase
    end

    // Frame sequencer and output register; loads the next word on each handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            n_q     <= '0;
            ng_q    <= '0;
            nc_q    <= '0;
            ovs_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            csum_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (start_i) begin
                        state_q <= ST_HDR;
                        row_q   <= '0;
                        col_q   <= '0;
                        n_q     <= Z.n;
                        ng_q    <= Z.ng;
                        nc_q    <= Z.nc;
                        ovs_q   <= ovs_in;
                        data_q  <= hdr_w;
                        valid_q <= 1'b1;
                        last_q  <= start_last;
                        busy_q  <= 1'b1;
                        csum_q  <= hdr_w;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    if (valid_q && m_ready_i) begin
                        if (last_q) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= ovs_q;
                        end else begin
                            state_q <= nxt_s;
                            row_q   <= nxt_r;
                            col_q   <= nxt_c;
                            data_q  <= nxt_word;
                            last_q  <= nxt_last;
                            csum_q  <= csum_q ^ nxt_word;
                        end
                    end
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;
    assign m_last_o  = last_q;
endmodule

// File: tb/tb_czonotope_streamer.sv
// Testbench for czonotope_streamer: frame contents predicted from Z with
// plain loops, compared word by word on every handshake.
module tb_czonotope_streamer;
    localparam int DW    = 32;
    localparam int NMAX  = 10;
    localparam int NGMAX = 5;
    localparam int NCMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, err, valid, last, ready;
    logic [DW-1:0] data;

    CZonotope #(.DATA_WIDTH(DW), .NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX)) zif ();

    czonotope_streamer #(.DATA_WIDTH(DW), .NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .Z         (zif),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .m_data_o  (data),
        .m_valid_o (valid),
        .m_ready_i (ready),
        .m_last_o  (last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] expq[$];
    int          idx = 0;
    bit          exp_err = 1'b0;
    bit          done_exp = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    int          rmode = 0;
    int          rcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected frame built directly from the frame-order rules.
    task automatic build_exp();
        bit          ovs;
        logic [31:0] x;
        expq.delete();
        ovs = (int'(zif.n) > NMAX) || (int'(zif.ng) > NGMAX) || (int'(zif.nc) > NCMAX);
        expq.push_back({(ovs ? 8'hCE : 8'hC2), zif.nc, zif.ng, zif.n});
        if (!ovs) begin
            for (int i = 0; i < int'(zif.n); i++) expq.push_back(zif.c[i]);
            for (int i = 0; i < int'(zif.n); i++)
                for (int j = 0; j < int'(zif.ng); j++) expq.push_back(zif.G[i][j]);
            for (int k = 0; k < int'(zif.nc); k++)
                for (int j = 0; j < int'(zif.ng); j++) expq.push_back(zif.A[k][j]);
            for (int k = 0; k < int'(zif.nc); k++) expq.push_back(zif.b[k]);
        end
`ifdef CZ_STREAM_CHECKSUM_EN
        x = '0;
        foreach (expq[i]) x = x ^ expq[i];
        expq.push_back(x);
`endif
        exp_err = ovs;
    endtask

    task automatic set_z(input int n, input int ng, input int nc);
        zif.n  = 8'(n);
        zif.ng = 8'(ng);
        zif.nc = 8'(nc);
        for (int i = 0; i < NMAX; i++) begin
            zif.c[i] = $urandom;
            for (int j = 0; j < NGMAX; j++) zif.G[i][j] = $urandom;
        end
        for (int k = 0; k < NCMAX; k++) begin
            zif.b[k] = $urandom;
            for (int j = 0; j < NGMAX; j++) zif.A[k][j] = $urandom;
        end
    endtask

    // Sink ready pattern: 0 always, 1 the 1-0-0 cycle, 2 random, 3 sparse random.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = (rcnt % 3 == 0);
                2:       ready = $urandom_range(0, 1) == 1;
                default: ready = $urandom_range(0, 3) == 0;
            endcase
        end
    end

    // Compare process: stream words, last flag, stall stability, done/err/busy.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            done_exp   = 1'b0;
        end else begin
            check("done", {31'd0, done}, {31'd0, done_exp});
            check("err", {31'd0, err}, {31'd0, done_exp && exp_err});
            if (done) check("busy_at_done", {31'd0, busy}, 32'd0);
            done_exp = 1'b0;
            if (stall_prev) begin
                check("hold_valid", {31'd0, valid}, 32'd1);
                check("hold_data", data, held_data);
                check("hold_last", {31'd0, last}, {31'd0, held_last});
            end
            if (valid) check("busy_while_valid", {31'd0, busy}, 32'd1);
            if (valid && ready) begin
                if (idx < expq.size()) begin
                    check("word", data, expq[idx]);
                    check("last", {31'd0, last}, {31'd0, idx == expq.size() - 1});
                    if (idx == expq.size() - 1) done_exp = 1'b1;
                end else begin
                    check("extra_word", 32'(idx), 32'(expq.size() - 1));
                end
                idx++;
            end
            stall_prev = valid && !ready;
            held_data  = data;
            held_last  = last;
        end
    end

    // One frame from start to the cycle after done; optional start noise while busy.
    task automatic run_frame(input int mode, input bit noisy);
        int cyc;
        build_exp();
        idx   = 0;
        rmode = mode;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("hdr_word", data, expq[0]);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!done && noisy) start = ($urandom_range(0, 1) == 1);
            else start = 1'b0;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 32'(cyc), 32'd0);
        else if (mode == 0) check("frame_cycles", 32'(cyc), 32'(expq.size()));
        check("word_count", 32'(idx), 32'(expq.size()));
        @(posedge clk);
        #1;
    endtask

    task automatic set_plan_z();
        set_z(2, 3, 1);
        zif.c[0] = 32'h40a00000; zif.c[1] = 32'h3f000000;
        zif.G[0][0] = 32'h3f000000; zif.G[0][1] = 32'h3f800000; zif.G[0][2] = 32'hbf000000;
        zif.G[1][0] = 32'h3f000000; zif.G[1][1] = 32'h3f000000; zif.G[1][2] = 32'h00000000;
        zif.A[0][0] = 32'h3f000000; zif.A[0][1] = 32'h3f800000; zif.A[0][2] = 32'hbf000000;
        zif.b[0] = 32'h3f800000;
    endtask

    initial begin
        int extra;
        int cyc;
`ifdef CZ_STREAM_CHECKSUM_EN
        extra = 1;
`else
        extra = 0;
`endif
        rst   = 1'b1;
        start = 1'b0;
        set_z(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_last", {31'd0, last}, 32'd0);
        check("rst_data", data, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Worked example, ready high then 1-0-0 stalls.
        set_plan_z();
        build_exp();
        check("model_len", 32'(expq.size()), 32'(13 + extra));
        check("model_hdr", expq[0], 32'hC2010302);
        check("model_g5", expq[8], 32'h00000000);
        check("model_b0", expq[12], 32'h3f800000);
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);

        // nc = 0 skips CON and BVEC.
        set_z(2, 2, 0);
        build_exp();
        check("model_len_nc0", 32'(expq.size()), 32'(7 + extra));
        check("model_hdr_nc0", expq[0], 32'hC2000202);
        run_frame(0, 1'b0);

        // Oversize constraint count: header-only frame with err.
        set_z(2, 3, 4);
        build_exp();
        check("model_len_ovs", 32'(expq.size()), 32'(1 + extra));
        check("model_hdr_ovs", expq[0], 32'hCE040302);
        run_frame(0, 1'b0);

        // Reset in the middle of GEN, then a clean restart.
        set_plan_z();
        build_exp();
        idx   = 0;
        rmode = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (idx < 5 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reach_gen", 32'(idx >= 5), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_last", {31'd0, last}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame(2, 1'b0);

        // Randomized frames, including empty and oversize dimensions.
        for (int t = 0; t < 40; t++) begin
            int n, ng, nc;
            n  = $urandom_range(0, NMAX);
            ng = $urandom_range(0, NGMAX);
            nc = $urandom_range(0, NCMAX);
            if ($urandom_range(0, 7) == 0) n  = NMAX + 1;
            if ($urandom_range(0, 7) == 0) ng = NGMAX + 2;
            if ($urandom_range(0, 7) == 0) nc = NCMAX + 1;
            set_z(n, ng, nc);
            run_frame($urandom_range(0, 3), t % 3 == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
